// File: rtl/cellrv32_npu_stride_counter.sv
// Strided address/index counter with wrap-back to a base value and optional pass counting.
// Define CELLRV32_NPU_CNT_PASS_EN to enable the pass counter and the DONE state.
module cellrv32_npu_stride_counter #(
  parameter int unsigned COUNTER_WIDTH = 32,
  parameter int unsigned PASS_WIDTH    = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     enable_i,
  input  logic                     load_i,
  input  logic [COUNTER_WIDTH-1:0] start_val_i,
  input  logic [COUNTER_WIDTH-1:0] stride_i,
  input  logic [COUNTER_WIDTH-1:0] limit_i,
  input  logic [PASS_WIDTH-1:0]    passes_i,
  output logic [COUNTER_WIDTH-1:0] count_val_o,
  output logic                     wrap_o,
  output logic                     busy_o,
  output logic                     done_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state;
  logic [COUNTER_WIDTH-1:0] base_r;
  logic [COUNTER_WIDTH-1:0] stride_r;
  logic [COUNTER_WIDTH-1:0] limit_r;
  logic [COUNTER_WIDTH:0]   sum;
  logic                     over;

  // One extra bit so an overflowing add is treated as exceeding the limit.
  assign sum  = {1'b0, count_val_o} + {1'b0, stride_r};
  assign over = sum > {1'b0, limit_r};

`ifdef CELLRV32_NPU_CNT_PASS_EN
  logic [PASS_WIDTH-1:0] passes_r;
  logic [PASS_WIDTH-1:0] pass_cnt_r;
  logic [PASS_WIDTH-1:0] pass_next;
  logic                  done_r;

  assign pass_next = pass_cnt_r + PASS_WIDTH'(1);
  assign done_o    = done_r;
`else
  logic unused_passes;

  assign unused_passes = ^passes_i;
  assign done_o        = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      base_r      <= '0;
      stride_r    <= '0;
      limit_r     <= '0;
      count_val_o <= '0;
      wrap_o      <= 1'b0;
      busy_o      <= 1'b0;
`ifdef CELLRV32_NPU_CNT_PASS_EN
      passes_r    <= '0;
      pass_cnt_r  <= '0;
      done_r      <= 1'b0;
`endif
    end else if (load_i) begin
      state       <= RUN;
      base_r      <= start_val_i;
      stride_r    <= stride_i;
      limit_r     <= limit_i;
      count_val_o <= start_val_i;
      wrap_o      <= 1'b0;
      busy_o      <= 1'b1;
`ifdef CELLRV32_NPU_CNT_PASS_EN
      passes_r    <= passes_i;
      pass_cnt_r  <= '0;
      done_r      <= 1'b0;
`endif
    end else begin
      case (state)
        RUN: begin
          wrap_o <= 1'b0;
          if (enable_i) begin
            if (!over) begin
              count_val_o <= sum[COUNTER_WIDTH-1:0];
            end else begin
              count_val_o <= base_r;
              wrap_o      <= 1'b1;
`ifdef CELLRV32_NPU_CNT_PASS_EN
              if (passes_r != '0) begin
                pass_cnt_r <= pass_next;
                if (pass_next == passes_r) begin
                  state  <= DONE;
                  busy_o <= 1'b0;
                  done_r <= 1'b1;
                end
              end else if (pass_cnt_r != '1) begin
                pass_cnt_r <= pass_next;
              end
`endif
            end
          end
        end
        DONE: wrap_o <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cellrv32_npu_stride_counter.sv
// Scoreboard bench for cellrv32_npu_stride_counter (COUNTER_WIDTH=8); expectations follow
// CELLRV32_NPU_CNT_PASS_EN so either build can be checked.
module tb_cellrv32_npu_stride_counter;

`ifdef CELLRV32_NPU_CNT_PASS_EN
  localparam bit PASS_EN = 1'b1;
`else
  localparam bit PASS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        enable_i = 1'b0;
  logic        load_i = 1'b0;
  logic [7:0]  start_val_i = '0;
  logic [7:0]  stride_i = '0;
  logic [7:0]  limit_i = '0;
  logic [15:0] passes_i = '0;
  logic [7:0]  count_val_o;
  logic        wrap_o;
  logic        busy_o;
  logic        done_o;

  typedef struct {
    string      nm;
    logic [7:0] c;
    logic       w;
    logic       b;
    logic       d;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  cellrv32_npu_stride_counter #(.COUNTER_WIDTH(8), .PASS_WIDTH(16)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .enable_i(enable_i), .load_i(load_i),
    .start_val_i(start_val_i), .stride_i(stride_i), .limit_i(limit_i),
    .passes_i(passes_i), .count_val_o(count_val_o), .wrap_o(wrap_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are valid every cycle; compare against the oldest expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (count_val_o !== e.c || wrap_o !== e.w || busy_o !== e.b || done_o !== e.d) begin
        failures++;
        $display("FAIL %s: got count=%0d wrap=%0b busy=%0b done=%0b, expected count=%0d wrap=%0b busy=%0b done=%0b",
                 e.nm, count_val_o, wrap_o, busy_o, done_o, e.c, e.w, e.b, e.d);
      end
    end
  end

  task automatic push(input string nm, input logic [7:0] c, input logic w, input logic b, input logic d);
    exp_t e;
    e.nm = nm; e.c = c; e.w = w; e.b = b; e.d = d;
    q.push_back(e);
  endtask

  task automatic step(input logic rn, input logic ld, input logic en,
                      input logic [7:0] c, input logic w, input logic b, input logic d,
                      input string nm);
    @(negedge clk);
    rstn_i = rn; load_i = ld; enable_i = en;
    @(posedge clk);
    #1 push(nm, c, w, b, d);
  endtask

  task automatic cfg(input logic [7:0] sv, input logic [7:0] st, input logic [7:0] lm, input logic [15:0] ps);
    start_val_i = sv; stride_i = st; limit_i = lm; passes_i = ps;
  endtask

  initial begin
    // Reset state
    step(0, 0, 0, 8'd0, 0, 0, 0, "reset");
    step(1, 0, 1, 8'd0, 0, 0, 0, "idle_ignores_enable");

    // Two passes
    cfg(8'd4, 8'd2, 8'd10, 16'd2);
    step(1, 1, 1, 8'd4, 0, 1, 0, "two_pass_load");
    cfg(8'd99, 8'd99, 8'd99, 16'd9);
    step(1, 0, 1, 8'd6, 0, 1, 0, "two_pass_6a");
    step(1, 0, 1, 8'd8, 0, 1, 0, "two_pass_8a");
    step(1, 0, 1, 8'd10, 0, 1, 0, "two_pass_10a");
    step(1, 0, 1, 8'd4, 1, 1, 0, "two_pass_wrap1");
    step(1, 0, 1, 8'd6, 0, 1, 0, "two_pass_6b");
    step(1, 0, 1, 8'd8, 0, 1, 0, "two_pass_8b");
    step(1, 0, 1, 8'd10, 0, 1, 0, "two_pass_10b");
    step(1, 0, 1, 8'd4, 1, !PASS_EN, PASS_EN, "two_pass_wrap2");
    step(1, 0, 1, PASS_EN ? 8'd4 : 8'd6, 0, !PASS_EN, PASS_EN, "two_pass_hold1");
    step(1, 0, 1, PASS_EN ? 8'd4 : 8'd8, 0, !PASS_EN, PASS_EN, "two_pass_hold2");

    // Enable gap, then reload mid-run
    cfg(8'd4, 8'd2, 8'd10, 16'd2);
    step(1, 1, 0, 8'd4, 0, 1, 0, "gap_load");
    step(1, 0, 1, 8'd6, 0, 1, 0, "gap_6");
    step(1, 0, 1, 8'd8, 0, 1, 0, "gap_8");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'd8, 0, 1, 0, "gap_hold");
    step(1, 0, 1, 8'd10, 0, 1, 0, "gap_resume_10");
    step(1, 0, 1, 8'd4, 1, 1, 0, "gap_resume_wrap");
    step(1, 0, 1, 8'd6, 0, 1, 0, "gap_6b");
    step(1, 0, 1, 8'd8, 0, 1, 0, "gap_8b");
    cfg(8'd20, 8'd2, 8'd30, 16'd1);
    step(1, 1, 1, 8'd20, 0, 1, 0, "reload_20");
    step(1, 0, 1, 8'd22, 0, 1, 0, "reload_22");
    step(1, 0, 1, 8'd24, 0, 1, 0, "reload_24");
    step(1, 0, 1, 8'd26, 0, 1, 0, "reload_26");
    step(1, 0, 1, 8'd28, 0, 1, 0, "reload_28");
    step(1, 0, 1, 8'd30, 0, 1, 0, "reload_30");
    step(1, 0, 1, 8'd20, 1, !PASS_EN, PASS_EN, "reload_pass_restart");

    // Overflow wrap with unlimited passes
    cfg(8'd250, 8'd4, 8'd255, 16'd0);
    step(1, 1, 1, 8'd250, 0, 1, 0, "ovf_load");
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 8'd254, 0, 1, 0, "ovf_254");
      step(1, 0, 1, 8'd250, 1, 1, 0, "ovf_wrap");
    end

    // Zero stride and base above limit
    cfg(8'd9, 8'd0, 8'd20, 16'd0);
    step(1, 1, 1, 8'd9, 0, 1, 0, "stride0_load");
    step(1, 0, 1, 8'd9, 0, 1, 0, "stride0_hold");
    cfg(8'd50, 8'd1, 8'd10, 16'd0);
    step(1, 1, 1, 8'd50, 0, 1, 0, "base_gt_limit_load");
    step(1, 0, 1, 8'd50, 1, 1, 0, "base_gt_limit_wrap1");
    step(1, 0, 1, 8'd50, 1, 1, 0, "base_gt_limit_wrap2");

    // Small range, single pass
    cfg(8'd0, 8'd1, 8'd3, 16'd1);
    step(1, 1, 1, 8'd0, 0, 1, 0, "cyc_load");
    step(1, 0, 1, 8'd1, 0, 1, 0, "cyc_1");
    step(1, 0, 1, 8'd2, 0, 1, 0, "cyc_2");
    step(1, 0, 1, 8'd3, 0, 1, 0, "cyc_3");
    step(1, 0, 1, 8'd0, 1, !PASS_EN, PASS_EN, "cyc_wrap1");
    step(1, 0, 1, PASS_EN ? 8'd0 : 8'd1, 0, !PASS_EN, PASS_EN, "cyc_after1");
    step(1, 0, 1, PASS_EN ? 8'd0 : 8'd2, 0, !PASS_EN, PASS_EN, "cyc_after2");
    step(1, 0, 1, PASS_EN ? 8'd0 : 8'd3, 0, !PASS_EN, PASS_EN, "cyc_after3");
    step(1, 0, 1, 8'd0, !PASS_EN, !PASS_EN, PASS_EN, "cyc_after4");

    // Asynchronous reset between edges
    cfg(8'd4, 8'd2, 8'd10, 16'd0);
    step(1, 1, 1, 8'd4, 0, 1, 0, "arst_load");
    step(1, 0, 1, 8'd6, 0, 1, 0, "arst_6");
    @(posedge clk);
    #3 rstn_i = 1'b0;
    push("arst_immediate", 8'd0, 0, 0, 0);
    step(0, 0, 1, 8'd0, 0, 0, 0, "arst_held");
    step(1, 0, 1, 8'd0, 0, 0, 0, "arst_idle1");
    step(1, 0, 1, 8'd0, 0, 0, 0, "arst_idle2");
    step(1, 1, 1, 8'd4, 0, 1, 0, "arst_reload");

    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
